if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {pc, inst} pairs in FIFO order.
- Decouples fetch from decode stalls using valid/ready handshakes on both sides.
- Discards all buffered instructions on a control-flow redirect (flush).
- Single clock domain.

---
 rtl/if_id_queue.sv | 88 ++++++++
 tb/tb_if_id_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {pc, inst} pairs
// with valid/ready handshakes on both sides and a single-cycle flush.
module if_id_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_pc,
   input  logic [31:0]      in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_pc,
   output logic [31:0]      out_inst,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic [63:0]      retired_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

   logic [63:0]      pc_mem_q   [DEPTH];
   logic [31:0]      inst_mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [63:0]      retired_q, retired_d;
   logic             push, pop;

   // Ready and valid derive only from registered occupancy; no path from out_ready.
   assign in_ready    = (count_q != FullCnt);
   assign out_valid   = (count_q != '0);
   assign push        = in_valid & in_ready & ~flush;
   assign pop         = out_valid & out_ready & ~flush;
   assign count       = count_q;
   assign retired_cnt = retired_q;
   assign out_pc      = out_valid ? pc_mem_q[head_q]   : '0;
   assign out_inst    = out_valid ? inst_mem_q[head_q] : '0;

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      retired_d = retired_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop) begin
            head_d    = head_q + 1'b1;
            retired_d = retired_q + 64'd1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         retired_q <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         retired_q <= retired_d;
      end
   end

   // Storage needs no reset: it is only observed through the empty mask.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         pc_mem_q[tail_q]   <= in_pc;
         inst_mem_q[tail_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue; each vector drives one cycle
// and checks all outputs just after the rising edge.
module tb_if_id_queue;

   logic        clock = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, flush;
   logic [63:0] in_pc, out_pc, retired_cnt;
   logic [31:0] in_inst, out_inst;
   logic [2:0]  count;

   typedef struct {
      logic        rst, fl, iv, ordy;
      logic [63:0] pc;
      logic [31:0] inst;
      logic        e_ir, e_ov;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
      logic [2:0]  e_cnt;
      logic [63:0] e_ret;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   if_id_queue #(.DEPTH(4), .CNT_W(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_inst     (in_inst),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .flush       (flush),
      .count       (count),
      .retired_cnt (retired_cnt)
   );

   always #5 clock = ~clock;

   task automatic add(input logic rst, input logic fl, input logic iv, input logic [63:0] pc,
                      input logic [31:0] inst, input logic ordy, input logic e_ir,
                      input logic e_ov, input logic [63:0] e_pc, input logic [31:0] e_inst,
                      input logic [2:0] e_cnt, input logic [63:0] e_ret);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
      v.e_cnt = e_cnt; v.e_ret = e_ret;
      vq.push_back(v);
   endtask

   task automatic step(input vec_t v, input string name);
      reset = v.rst; flush = v.fl; in_valid = v.iv; in_pc = v.pc;
      in_inst = v.inst; out_ready = v.ordy;
      @(posedge clock);
      #1;
      n_vec++;
      if (in_ready !== v.e_ir || out_valid !== v.e_ov || out_pc !== v.e_pc ||
          out_inst !== v.e_inst || count !== v.e_cnt || retired_cnt !== v.e_ret) begin
         n_err++;
         $display("FAIL %s: got ir=%b ov=%b pc=%h inst=%h cnt=%0d ret=%0d, want ir=%b ov=%b pc=%h inst=%h cnt=%0d ret=%0d",
                  name, in_ready, out_valid, out_pc, out_inst, count, retired_cnt,
                  v.e_ir, v.e_ov, v.e_pc, v.e_inst, v.e_cnt, v.e_ret);
      end
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0;

      // Reset, then idle
      add(1,0,0,0,0,0, 1,0,0,0,0,0);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 1,0,0,0,0,0);
      // Fill with out_ready low; fifth push refused
      add(0,0,1,64'h80000000,32'h00000413,0, 1,1,64'h80000000,32'h00000413,1,0);
      add(0,0,1,64'h80000004,32'h00100513,0, 1,1,64'h80000000,32'h00000413,2,0);
      add(0,0,1,64'h80000008,32'h00A00593,0, 1,1,64'h80000000,32'h00000413,3,0);
      add(0,0,1,64'h8000000C,32'h00100073,0, 0,1,64'h80000000,32'h00000413,4,0);
      add(0,0,1,64'h80000010,32'h00000013,0, 0,1,64'h80000000,32'h00000413,4,0);
      // Drain in order
      add(0,0,0,0,0,1, 1,1,64'h80000004,32'h00100513,3,1);
      add(0,0,0,0,0,1, 1,1,64'h80000008,32'h00A00593,2,2);
      add(0,0,0,0,0,1, 1,1,64'h8000000C,32'h00100073,1,3);
      add(0,0,0,0,0,1, 1,0,0,0,0,4);
      add(0,0,0,0,0,1, 1,0,0,0,0,4);
      // Refill, then full queue with both handshakes: pop only
      add(0,0,1,64'h80000020,32'h11,0, 1,1,64'h80000020,32'h11,1,4);
      add(0,0,1,64'h80000024,32'h22,0, 1,1,64'h80000020,32'h11,2,4);
      add(0,0,1,64'h80000028,32'h33,0, 1,1,64'h80000020,32'h11,3,4);
      add(0,0,1,64'h8000002C,32'h44,0, 0,1,64'h80000020,32'h11,4,4);
      add(0,0,1,64'h80000030,32'h55,1, 1,1,64'h80000024,32'h22,3,5);
      // Flush with push and pop requests at count 3
      add(0,1,1,64'h80000100,32'h66,1, 1,0,0,0,0,5);
      add(0,0,1,64'h80000200,32'h77,0, 1,1,64'h80000200,32'h77,1,5);
      add(0,0,0,0,0,1, 1,0,0,0,0,6);
      // Reset mid-operation at count 2
      add(0,0,1,64'h80000300,32'h88,0, 1,1,64'h80000300,32'h88,1,6);
      add(0,0,1,64'h80000304,32'h99,0, 1,1,64'h80000300,32'h88,2,6);
      add(1,0,1,64'h80000308,32'hAA,1, 1,0,0,0,0,0);
      add(0,0,1,64'h80000000,32'h00000413,1, 1,1,64'h80000000,32'h00000413,1,0);
      add(0,0,0,0,0,1, 1,0,0,0,0,1);

      foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

      // Streaming from empty: 20 cycles of push+pop across pointer wrap
      v = '{rst:1, fl:0, iv:0, ordy:0, pc:0, inst:0,
            e_ir:1, e_ov:0, e_pc:0, e_inst:0, e_cnt:0, e_ret:0};
      step(v, "stream_reset");
      for (int k = 0; k < 20; k++) begin
         v.rst = 0; v.iv = 1; v.ordy = 1;
         v.pc = 64'h80001000 + 64'(4 * k);
         v.inst = 32'h1000 + 32'(k);
         v.e_ir = 1; v.e_ov = 1; v.e_pc = v.pc; v.e_inst = v.inst;
         v.e_cnt = 1; v.e_ret = 64'(k);
         step(v, $sformatf("stream%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
